// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo PWM bank, plus the clamp and
// slew helpers used by every channel.
package servo_pkg;

  localparam int NUM_SERVOS  = 5;

  typedef logic [14:0] servo_us_t;

  localparam int MIN_US_DEF  = 500;
  localparam int MAX_US_DEF  = 2500;
  localparam int HOME_US_DEF = 1500;
  localparam int STEP_US_DEF = 10;

  // Limit a requested width to the legal window [lo, hi].
  function automatic servo_us_t clamp_us(input servo_us_t v,
                                         input servo_us_t lo,
                                         input servo_us_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // One frame of slew: move cur toward tgt by at most step. The distance is
  // taken in the direction of travel, so neither add nor subtract can wrap.
  function automatic servo_us_t slew_us(input servo_us_t cur,
                                        input servo_us_t tgt,
                                        input servo_us_t step);
    servo_us_t diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > step) ? cur + step : tgt;
    end
    if (cur > tgt) begin
      diff = cur - tgt;
      return (diff > step) ? cur - step : tgt;
    end
    return cur;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo output: clamped target register, per-frame slew of the current
// width, and the registered width-versus-counter compare that drives pwm.
module servo_channel
  import servo_pkg::*;
#(
  parameter int MIN_US  = MIN_US_DEF,
  parameter int MAX_US  = MAX_US_DEF,
  parameter int HOME_US = HOME_US_DEF,
  parameter int STEP_US = STEP_US_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_load,
  input  logic      i_wrap,
  input  servo_us_t i_us_cnt,
  input  servo_us_t i_target_us,
  output logic      o_pwm,
  output logic      o_differs
);

  localparam servo_us_t MIN_V  = servo_us_t'(MIN_US);
  localparam servo_us_t MAX_V  = servo_us_t'(MAX_US);
  localparam servo_us_t HOME_V = servo_us_t'(HOME_US);
  localparam servo_us_t STEP_V = servo_us_t'(STEP_US);

  servo_us_t r_tgt;
  servo_us_t r_cur;
  logic      r_pwm;

  // Capture clamped targets, slew at frame wrap (reading the pre-load target
  // when both happen together), and register the pulse compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tgt <= HOME_V;
      r_cur <= HOME_V;
      r_pwm <= 1'b0;
    end else begin
      if (i_load) r_tgt <= clamp_us(i_target_us, MIN_V, MAX_V);
      if (i_wrap) r_cur <= slew_us(r_cur, r_tgt, STEP_V);
      r_pwm <= (i_us_cnt < r_cur);
    end
  end

  assign o_pwm     = r_pwm;
  assign o_differs = (r_cur != r_tgt);

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of NUM_SERVOS hobby-servo PWM outputs sharing one microsecond
// prescaler and frame counter. Widths ramp toward their targets by a bounded
// step once per frame.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int FRAME_US = 20000,
  parameter int MIN_US   = MIN_US_DEF,
  parameter int MAX_US   = MAX_US_DEF,
  parameter int HOME_US  = HOME_US_DEF,
  parameter int STEP_US  = STEP_US_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  servo_us_t [NUM_SERVOS-1:0]  target_us,
  output logic      [NUM_SERVOS-1:0]  pwm,
  output logic                        frame_start,
  output logic                        busy
);

  localparam int                PRE_DIV    = CLK_HZ / 1_000_000;
  localparam int                PRE_W      = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PRE_DIV - 1);
  localparam servo_us_t         FRAME_LAST = servo_us_t'(FRAME_US - 1);

  logic [PRE_W-1:0]      r_pre;
  servo_us_t             r_us_cnt;
  logic                  r_frame_start;
  logic                  r_busy;
  logic                  w_us_tick;
  logic                  w_wrap;
  logic [NUM_SERVOS-1:0] w_pwm;
  logic [NUM_SERVOS-1:0] w_differs;

  assign w_us_tick = (r_pre == PRE_LAST);
  assign w_wrap    = w_us_tick && (r_us_cnt == FRAME_LAST);

  // Divide the clock down to one tick per microsecond.
  always_ff @(posedge clk) begin
    if (reset)          r_pre <= '0;
    else if (w_us_tick) r_pre <= '0;
    else                r_pre <= r_pre + PRE_W'(1);
  end

  // Microsecond position within the frame; wraps exactly at FRAME_US.
  always_ff @(posedge clk) begin
    if (reset)          r_us_cnt <= '0;
    else if (w_wrap)    r_us_cnt <= '0;
    else if (w_us_tick) r_us_cnt <= r_us_cnt + servo_us_t'(1);
  end

  // Registered frame marker and "still ramping" flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_start <= w_wrap;
      r_busy        <= |w_differs;
    end
  end

  for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_ch
    servo_channel #(
      .MIN_US  (MIN_US),
      .MAX_US  (MAX_US),
      .HOME_US (HOME_US),
      .STEP_US (STEP_US)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_load      (load),
      .i_wrap      (w_wrap),
      .i_us_cnt    (r_us_cnt),
      .i_target_us (target_us[g]),
      .o_pwm       (w_pwm[g]),
      .o_differs   (w_differs[g])
    );
  end

  assign pwm         = w_pwm;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

endmodule

// File: doc/servo_pwm_bank.md
SERVO_PWM_BANK -- requirements
Module: servo_pwm_bank

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency.
REQ-002 Parameter FRAME_US, default 20000, PWM frame period in microseconds.
REQ-003 Parameter MIN_US, default 500; MAX_US, default 2500, the legal pulse-width bounds.
REQ-004 Parameter HOME_US, default 1500, reset pulse width; STEP_US, default 10, maximum width change per frame.
REQ-005 Port clk, input, 1, single clock.
REQ-006 Port reset, input, 1, synchronous and active-high.
REQ-007 Port load, input, 1, one-cycle strobe that captures target_us.
REQ-008 Port target_us, input, 5x15 (servo_us_t[4:0]), requested pulse width per channel, in us.
REQ-009 Port pwm, output, 5, servo drive; bit i feeds top-level pwm(i+1).
REQ-010 Port frame_start, output, 1, one-cycle pulse at each frame start.
REQ-011 Port busy, output, 1, high while any channel's current width differs from its target.

Function
REQ-012 The us prescaler shall count 0..CLK_HZ/1e6-1 and assert us_tick on the terminal count.
REQ-013 The frame counter us_cnt shall advance on us_tick over 0..FRAME_US-1, then wrap to 0.
REQ-014 Wrap event: the cycle where us_tick is high and us_cnt==FRAME_US-1.
REQ-015 On load, each target[i] shall be captured clamped: below MIN_US -> MIN_US, above MAX_US -> MAX_US, otherwise unchanged.
REQ-016 On each wrap event, cur[i] shall move toward target[i] by min(STEP_US, |target-cur|), using unsigned compare with no overflow.
REQ-017 If load and the wrap event coincide, the slew step shall use the old targets and the new targets shall be captured in the same cycle.
REQ-018 A load during a ramp shall redirect the next step toward the new target, including a reversal of direction.
REQ-019 pwm[i] shall be a register equal to (us_cnt < cur[i]), giving 1 clk latency from the counter and no combinational output path.
REQ-020 frame_start shall be a registered pulse, high for exactly one clk in the cycle after the wrap event.
REQ-021 busy shall be registered: OR over i of (cur[i] != target[i]).
REQ-022 The frame period shall be exactly FRAME_US*CLK_HZ/1e6 clocks with no drift.

Reset
REQ-023 While reset is high at a clk edge, the prescaler and us_cnt shall go to 0, cur[i] and target[i] to HOME_US, pwm to 0, frame_start to 0 and busy to 0.
REQ-024 Reset shall take priority over load.
REQ-025 A reset mid-frame shall force pwm low on the next edge, and a fresh frame shall start at us_cnt=0 after release.
REQ-026 In the first cycle after release, pwm shall rise on all channels, since 0 < HOME_US.

Structure
REQ-027 Package servo_pkg shall hold NUM_SERVOS=5, typedef servo_us_t (logic [14:0]) and the default MIN/MAX/HOME/STEP constants.
REQ-028 Sub-module servo_channel shall hold the per-channel target register, clamp, slew and compare.
REQ-029 servo_channel shall be instantiated NUM_SERVOS times in a generate loop.
REQ-030 The shared prescaler, frame counter, frame_start and busy-reduce logic shall stay in servo_pwm_bank.

Verification
REQ-031 Bench parameters shall be CLK_HZ=50_000_000 and FRAME_US=20000, with the clock 20 ns, using the defaults; the bench may shorten FRAME_US to 3000, and then both bounds scale.
REQ-032 Reset then idle -> each pwm high for 75,000 clks and low for 925,000 clks, frame_start period 1,000,000 clks, busy=0.
REQ-033 Load ch0=1600 (others 1500) -> ch0 widths 1510, 1520, ..., 1600 over 10 frames; busy falls the cycle after the 10th wrap.
REQ-034 Load ch1=3000, then later ch1=100 -> ch1 ramps toward 2500 and stops there; after the second load it ramps down and stops at 500.
REQ-035 Load ch2=1800, then after 5 frames (width 1550) load 1500 -> widths 1540, 1530, ..., 1500.
REQ-036 Load asserted on the wrap cycle with ch3=1700 -> the coming frame keeps the old width; the following frame is 1510.
REQ-037 Reset asserted at us_cnt=300 mid-ramp -> pwm=0 on the next edge, busy=0, and after release the width is 1500.
